// File: rtl/intf_slice_pkg.sv
// Shared types and the range helper for the slice loader and its address unit.
package intf_slice_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // True when idx lies in the declared range lo .. lo+n-1; below-lo counts as out of range.
    function automatic logic in_range(input int idx, input int lo, input int n);
        return (idx >= lo) && ((idx - lo) < n);
    endfunction

endpackage

// File: rtl/intf_slice_addr.sv
// Slice address unit: validates and latches the slice bounds, then walks the slot
// pointer toward the end bound in the slice's direction.
module intf_slice_addr
    import intf_slice_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_LO    = 1,
    parameter int IDX_W     = 8,
    parameter int PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [IDX_W-1:0] first_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             bounds_ok_o,
    output logic [PTR_W-1:0] ptr_o,
    output logic             at_end_o
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] end_reg;
    dir_t             dir_reg;

    assign bounds_ok_o = in_range(int'(first_i), IDX_LO, NUM_SLOTS) &&
                         in_range(int'(last_i),  IDX_LO, NUM_SLOTS);

    // Offsets are formed one bit wider than the index so a negative result cannot alias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
            end_reg <= '0;
            dir_reg <= DIR_UP;
        end else if (load_i) begin
            ptr_reg <= PTR_W'({1'b0, first_i} - (IDX_W+1)'(IDX_LO));
            end_reg <= PTR_W'({1'b0, last_i}  - (IDX_W+1)'(IDX_LO));
            dir_reg <= (last_i < first_i) ? DIR_DOWN : DIR_UP;
        end else if (step_i) begin
            ptr_reg <= (dir_reg == DIR_UP) ? ptr_reg + 1'b1 : ptr_reg - 1'b1;
        end
    end

    assign ptr_o    = ptr_reg;
    assign at_end_o = (ptr_reg == end_reg);

endmodule

// File: rtl/intf_slice_loader.sv
// Slice loader: fills NUM_SLOTS slot words from a ready/valid stream in slice order.
// Optional readback port enabled by defining INTF_SLICE_LOADER_READBACK_EN.
module intf_slice_loader
    import intf_slice_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int DATA_W    = 32,
    parameter int IDX_LO    = 1,
    parameter int IDX_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [IDX_W-1:0]            first_i,
    input  logic [IDX_W-1:0]            last_i,
    input  logic                        in_valid_i,
    input  logic [DATA_W-1:0]           in_data_i,
    output logic                        in_ready_o,
    output logic [NUM_SLOTS*DATA_W-1:0] slot_data_o,
    output logic [NUM_SLOTS-1:0]        slot_vld_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    input  logic                        clear_i
`ifdef INTF_SLICE_LOADER_READBACK_EN
    ,
    input  logic [IDX_W-1:0]            rd_idx_i,
    output logic [DATA_W-1:0]           rd_data_o,
    output logic                        rd_hit_o
`endif
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    state_t           state_reg, state_next;
    logic             err_reg;
    logic             bounds_ok;
    logic             at_end;
    logic [PTR_W-1:0] ptr;
    logic             accept;
    logic             load;
    logic             step;
    logic             clear_en;

    assign accept   = (state_reg == LOAD) && in_valid_i;
    assign load     = (state_reg == IDLE) && start_i && bounds_ok;
    assign step     = accept && !at_end;
    assign clear_en = clear_i && (state_reg != LOAD);

    intf_slice_addr #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_LO    (IDX_LO),
        .IDX_W     (IDX_W),
        .PTR_W     (PTR_W)
    ) u_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .step_i      (step),
        .first_i     (first_i),
        .last_i      (last_i),
        .bounds_ok_o (bounds_ok),
        .ptr_o       (ptr),
        .at_end_o    (at_end)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = LOAD;
            LOAD:    if (accept && at_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= (state_reg == IDLE) && start_i && !bounds_ok;
        end
    end

    // Status outputs decode straight from registered state, so they change only on edges.
    assign busy_o     = (state_reg == LOAD);
    assign in_ready_o = (state_reg == LOAD);
    assign done_o     = (state_reg == DONE);
    assign err_o      = err_reg;

    // Writes happen only in LOAD and clears only outside it, so they never collide.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        logic [DATA_W-1:0] data_reg;
        logic              vld_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg <= '0;
                vld_reg  <= 1'b0;
            end else if (accept && (ptr == PTR_W'(gi))) begin
                data_reg <= in_data_i;
                vld_reg  <= 1'b1;
            end else if (clear_en) begin
                vld_reg  <= 1'b0;
            end
        end

        assign slot_data_o[gi*DATA_W +: DATA_W] = data_reg;
        assign slot_vld_o[gi]                   = vld_reg;
    end

`ifdef INTF_SLICE_LOADER_READBACK_EN
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_ok;

    assign rd_ptr = PTR_W'({1'b0, rd_idx_i} - (IDX_W+1)'(IDX_LO));
    assign rd_ok  = in_range(int'(rd_idx_i), IDX_LO, NUM_SLOTS) && slot_vld_o[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
            rd_hit_o  <= 1'b0;
        end else begin
            rd_data_o <= rd_ok ? slot_data_o[rd_ptr*DATA_W +: DATA_W] : '0;
            rd_hit_o  <= rd_ok;
        end
    end
`endif

endmodule

// File: tb/tb_intf_slice_loader.sv
// Directed bench for intf_slice_loader; readback checks build when
// INTF_SLICE_LOADER_READBACK_EN is defined.
module tb_intf_slice_loader;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [7:0]   first_i;
    logic [7:0]   last_i;
    logic         in_valid_i;
    logic [31:0]  in_data_i;
    logic         in_ready_o;
    logic [127:0] slot_data_o;
    logic [3:0]   slot_vld_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic         clear_i;
`ifdef INTF_SLICE_LOADER_READBACK_EN
    logic [7:0]   rd_idx_i;
    logic [31:0]  rd_data_o;
    logic         rd_hit_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    intf_slice_loader #(
        .NUM_SLOTS (4),
        .DATA_W    (32),
        .IDX_LO    (1),
        .IDX_W     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .first_i     (first_i),
        .last_i      (last_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .slot_data_o (slot_data_o),
        .slot_vld_o  (slot_vld_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .clear_i     (clear_i)
`ifdef INTF_SLICE_LOADER_READBACK_EN
        ,
        .rd_idx_i    (rd_idx_i),
        .rd_data_o   (rd_data_o),
        .rd_hit_o    (rd_hit_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] slot(input int k);
        return slot_data_o[k*32 +: 32];
    endfunction

    initial begin
        rst_n = 1'b0; start_i = 1'b0; first_i = '0; last_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; clear_i = 1'b0;
`ifdef INTF_SLICE_LOADER_READBACK_EN
        rd_idx_i = '0;
`endif
        #12;
        chk("rst_data",  slot_data_o, 128'h0);
        chk("rst_vld",   slot_vld_o, 4'h0);
        chk("rst_ready", in_ready_o, 1'b0);
        chk("rst_busy",  busy_o, 1'b0);
        chk("rst_done",  done_o, 1'b0);
        chk("rst_err",   err_o, 1'b0);
        rst_n = 1'b1;

        // Ascending slice 1..2
        tick();
        start_i = 1'b1; first_i = 8'd1; last_i = 8'd2;
        tick();
        start_i = 1'b0;
        chk("asc_busy",  busy_o, 1'b1);
        chk("asc_ready", in_ready_o, 1'b1);
        in_valid_i = 1'b1; in_data_i = 32'h101;
        tick();
        chk("asc_s0",    slot(0), 32'h101);
        chk("asc_vld0",  slot_vld_o, 4'b0001);
        chk("asc_nodn",  done_o, 1'b0);
        in_data_i = 32'h102;
        tick();
        in_valid_i = 1'b0;
        chk("asc_s1",    slot(1), 32'h102);
        chk("asc_vld",   slot_vld_o, 4'b0011);
        chk("asc_done",  done_o, 1'b1);
        chk("asc_dnbusy", busy_o, 1'b0);
        chk("asc_dnrdy", in_ready_o, 1'b0);
        tick();
        chk("asc_done0", done_o, 1'b0);

`ifdef INTF_SLICE_LOADER_READBACK_EN
        rd_idx_i = 8'd2;
        tick();
        chk("rb_data2",  rd_data_o, 32'h102);
        chk("rb_hit2",   rd_hit_o, 1'b1);
        rd_idx_i = 8'd4;
        tick();
        chk("rb_data4",  rd_data_o, 32'h0);
        chk("rb_hit4",   rd_hit_o, 1'b0);
`endif

        // Descending slice 4..3
        start_i = 1'b1; first_i = 8'd4; last_i = 8'd3;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h204;
        tick();
        chk("dsc_s3",    slot(3), 32'h204);
        chk("dsc_vld1",  slot_vld_o, 4'b1011);
        in_data_i = 32'h203;
        tick();
        in_valid_i = 1'b0;
        chk("dsc_all",   slot_data_o, 128'h00000204_00000203_00000102_00000101);
        chk("dsc_vld",   slot_vld_o, 4'b1111);
        chk("dsc_done",  done_o, 1'b1);
        tick();

        // Range errors on either bound
        start_i = 1'b1; first_i = 8'd0; last_i = 8'd2;
        tick();
        start_i = 1'b0;
        chk("err0_err",  err_o, 1'b1);
        chk("err0_busy", busy_o, 1'b0);
        tick();
        chk("err0_clr",  err_o, 1'b0);
        chk("err0_vld",  slot_vld_o, 4'b1111);
        start_i = 1'b1; first_i = 8'd1; last_i = 8'd5;
        tick();
        start_i = 1'b0;
        chk("err5_err",  err_o, 1'b1);
        chk("err5_busy", busy_o, 1'b0);
        tick();
        chk("err5_clr",  err_o, 1'b0);
        chk("err5_data", slot_data_o, 128'h00000204_00000203_00000102_00000101);

        // Clear together with a single-slot start, then backpressure
        clear_i = 1'b1; start_i = 1'b1; first_i = 8'd3; last_i = 8'd3;
        tick();
        clear_i = 1'b0; start_i = 1'b0;
        chk("clr_vld",   slot_vld_o, 4'b0000);
        chk("clr_keep",  slot(0), 32'h101);
        for (int i = 0; i < 5; i++) begin
            chk("bp_busy",  busy_o, 1'b1);
            chk("bp_done",  done_o, 1'b0);
            tick();
        end
        in_valid_i = 1'b1; in_data_i = 32'h303;
        tick();
        in_valid_i = 1'b0;
        chk("bp_s2",     slot(2), 32'h303);
        chk("bp_vld",    slot_vld_o, 4'b0100);
        chk("bp_done1",  done_o, 1'b1);
        tick();
        chk("bp_done0",  done_o, 1'b0);

        // Reset after the first word of a 4-word load
        start_i = 1'b1; first_i = 8'd1; last_i = 8'd4;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h301;
        tick();
        in_valid_i = 1'b0;
        chk("mid_s0",    slot(0), 32'h301);
        rst_n = 1'b0;
        #2;
        chk("mrst_data", slot_data_o, 128'h0);
        chk("mrst_vld",  slot_vld_o, 4'h0);
        chk("mrst_busy", busy_o, 1'b0);
        chk("mrst_rdy",  in_ready_o, 1'b0);
        chk("mrst_done", done_o, 1'b0);
        chk("mrst_err",  err_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        start_i = 1'b1; first_i = 8'd1; last_i = 8'd4;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid_i = 1'b1; in_data_i = 32'h301 + 32'(k);
            tick();
        end
        in_valid_i = 1'b0;
        chk("full_data", slot_data_o, 128'h00000304_00000303_00000302_00000301);
        chk("full_vld",  slot_vld_o, 4'b1111);
        chk("full_done", done_o, 1'b1);
        tick();
        chk("full_idle", busy_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
